// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS subset core (add/sub/and/or/slt/addi/lw/sw/beq/j), one shared ALU, 5-state FSM.
// Latency per instruction: j 2, beq 3, R-type/addi/sw 4, lw 5 cycles; external sync-read RAMs return data one cycle after address.
// Backpressure: counterLd=0 freezes every state element and masks strobes; perf counters exist only with MIPS_PERF_CNT_EN.
module mips_multicycle_core #(
  parameter int DATA_W  = 32,
  parameter int IMEM_AW = 5,
  parameter int DMEM_AW = 9,
  parameter int REG_AW  = 5
) (
  input  logic               clk,
  input  logic               counterRst,
  input  logic               counterLd,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [IMEM_AW-1:0] pc,
  output logic               retire,
  output logic               illegal,
  input  logic [REG_AW-1:0]  dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0]        retired_cnt,
  output logic [31:0]        cycle_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  logic [DATA_W-1:0]  rf_q [0:(1<<REG_AW)-1];

  logic               rf_we;
  logic [REG_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;

  logic [5:0]         ir_op, ir_fn;
  logic [DATA_W-1:0]  sext_imm;
  logic [IMEM_AW-1:0] pc_inc, pc_br;
  logic               dec_legal;
  logic               unused_ir_rs;

  assign ir_op    = ir_q[31:26];
  assign ir_fn    = ir_q[5:0];
  assign sext_imm = DATA_W'($signed(ir_q[15:0]));
  assign pc_inc   = pc_q + IMEM_AW'(1);
  assign pc_br    = pc_inc + sext_imm[IMEM_AW-1:0];

  // rs is only needed at decode, where it is taken straight from imem_data
  assign unused_ir_rs = ^ir_q[25:21];

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dmem_addr  = alu_q[DMEM_AW-1:0];
  assign dmem_wdata = b_q;
  assign dbg_rdata  = rf_q[dbg_raddr];

  // Classify the word arriving from instruction memory as supported or not
  always_comb begin
    dec_legal = 1'b0;
    case (imem_data[31:26])
      OP_RTYPE: dec_legal = imem_data[5:0] inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: dec_legal = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state, datapath next values and strobes for the current FSM state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    retire   = 1'b0;
    illegal  = 1'b0;
    dmem_we  = 1'b0;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // Operands are read with the fields of the word being latched this cycle
        ir_d = imem_data;
        a_d  = rf_q[imem_data[21 +: REG_AW]];
        b_d  = rf_q[imem_data[16 +: REG_AW]];
        if (imem_data[31:26] == OP_J) begin
          pc_d    = imem_data[IMEM_AW-1:0];
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (!dec_legal) begin
          pc_d    = pc_inc;
          illegal = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (ir_op)
          OP_RTYPE: begin
            case (ir_fn)
              FN_ADD:  alu_d = a_q + b_q;
              FN_SUB:  alu_d = a_q - b_q;
              FN_AND:  alu_d = a_q & b_q;
              FN_OR:   alu_d = a_q | b_q;
              FN_SLT:  alu_d = DATA_W'($signed(a_q) < $signed(b_q));
              default: alu_d = alu_q;
            endcase
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_d   = a_q + sext_imm;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = a_q + sext_imm;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            pc_d    = (a_q == b_q) ? pc_br : pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          // IR only reaches EXEC holding a legal non-jump op
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (ir_op == OP_SW) begin
          dmem_we = 1'b1;
          pc_d    = pc_inc;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        retire  = 1'b1;
        rf_we   = 1'b1;
        state_d = S_FETCH;
        case (ir_op)
          OP_RTYPE: begin
            rf_waddr = ir_q[11 +: REG_AW];
            rf_wdata = alu_q;
          end
          OP_ADDI: begin
            rf_waddr = ir_q[16 +: REG_AW];
            rf_wdata = alu_q;
          end
          default: begin
            rf_waddr = ir_q[16 +: REG_AW];
            rf_wdata = dmem_rdata;
          end
        endcase
      end
      default: state_d = S_FETCH;
    endcase
    // A frozen core must not emit events; the store strobe in particular
    if (!counterLd) begin
      retire  = 1'b0;
      illegal = 1'b0;
      dmem_we = 1'b0;
    end
  end

  // FSM state and datapath registers, advanced only while running
  always_ff @(posedge clk or posedge counterRst) begin
    if (counterRst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
    end else if (counterLd) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
    end
  end

  // Register file; entry 0 is never written so it always reads zero
  always_ff @(posedge clk or posedge counterRst) begin
    if (counterRst) begin
      for (int i = 0; i < (1 << REG_AW); i++) rf_q[i] <= '0;
    end else if (counterLd && rf_we && (rf_waddr != '0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

`ifdef MIPS_PERF_CNT_EN
  logic [31:0] retired_cnt_q, cycle_cnt_q;

  // Free-running cycle and retirement counters, wrapping at 2^32
  always_ff @(posedge clk or posedge counterRst) begin
    if (counterRst) begin
      retired_cnt_q <= '0;
      cycle_cnt_q   <= '0;
    end else if (counterLd) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (retire) retired_cnt_q <= retired_cnt_q + 32'd1;
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

  logic        clk;
  logic        counterRst;
  logic        counterLd;
  logic [4:0]  imem_addr;
  logic [31:0] imem_data;
  logic [8:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic [4:0]  pc;
  logic        retire;
  logic        illegal;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] cycle_cnt;
`endif

  mips_multicycle_core dut (
    .clk        (clk),
    .counterRst (counterRst),
    .counterLd  (counterLd),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .retire     (retire),
    .illegal    (illegal),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
`ifdef MIPS_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt),
    .cycle_cnt  (cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // External synchronous-read memories
  logic [31:0] imem [0:31];
  logic [31:0] dmem [0:511];
  always @(posedge clk) begin
    imem_data  <= imem[imem_addr];
    dmem_rdata <= dmem[dmem_addr];
    if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  // Architectural reference state
  logic [31:0] m_reg [0:31];
  logic [31:0] m_mem [0:511];
  logic [4:0]  m_pc;

  int checks = 0;
  int failures = 0;
  int retires = 0;
  int tot_cyc = 0;
  int last_lat;
  int last_ill;
  int store_abs;
  logic [8:0]  last_we_a;
  logic [31:0] last_we_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #5;
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    if (idx != 5'd0) m_reg[idx] = val;
  endtask

  // ISA-level model: one whole instruction at a time
  task automatic model_exec(input logic [31:0] ins, output int lat, output int st,
                            output logic [8:0] sa, output logic [31:0] sd, output int ill);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic [31:0] a, b, simm, ea;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    simm = {{16{ins[15]}}, ins[15:0]};
    a = m_reg[rs];
    b = m_reg[rt];
    ea = a + simm;
    lat = 4; st = 0; sa = '0; sd = '0; ill = 0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: wr(rd, a + b);
          6'h22: wr(rd, a - b);
          6'h24: wr(rd, a & b);
          6'h25: wr(rd, a | b);
          6'h2A: wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: ill = 1;
        endcase
      end
      6'h08: wr(rt, ea);
      6'h23: begin lat = 5; wr(rt, m_mem[ea[8:0]]); end
      6'h2B: begin st = 1; sa = ea[8:0]; sd = b; m_mem[ea[8:0]] = b; end
      6'h04: lat = 3;
      6'h02: lat = 2;
      default: ill = 1;
    endcase
    if (ill != 0) begin
      lat = 2;
      m_pc = m_pc + 5'd1;
    end else if (op == 6'h02) m_pc = ins[4:0];
    else if (op == 6'h04 && a == b) m_pc = m_pc + 5'd1 + simm[4:0];
    else m_pc = m_pc + 5'd1;
  endtask

  task automatic sweep_regs();
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i);
      #1;
      chk($sformatf("reg_r%0d", i), dbg_rdata, m_reg[i]);
    end
  endtask

  // Run one instruction from FETCH to its retire edge, optionally freezing it for a while
  task automatic run_instr(input logic [31:0] ins, input int stall_at, input int stall_len);
    int lat_e, st_e, ill_e, cyc, we_n, we_cyc, ill_n;
    logic [8:0]  sa_e, we_a;
    logic [31:0] sd_e, we_d;
    logic [4:0]  pc0;
    bit done;
    pc0 = m_pc;
    model_exec(ins, lat_e, st_e, sa_e, sd_e, ill_e);
    imem[pc0] = ins;
    chk("start_imem_addr", 32'(imem_addr), 32'(pc0));
    chk("start_retire_low", 32'(retire), 32'd0);
    cyc = 1; we_n = 0; we_cyc = 0; ill_n = 0; we_a = '0; we_d = '0; done = 0;
    while (!done) begin
      if (cyc == stall_at) begin
        counterLd = 1'b0;
        repeat (stall_len) begin
          #1;
          chk("stall_dmem_we", 32'(dmem_we), 32'd0);
          chk("stall_pc", 32'(pc), 32'(pc0));
          step();
        end
        counterLd = 1'b1;
        #1;
      end
      if (dmem_we) begin we_n++; we_cyc = cyc; we_a = dmem_addr; we_d = dmem_wdata; end
      if (illegal) ill_n++;
      if (retire) begin
        done = 1;
        retires++;
      end else begin
        step();
        cyc++;
        if (cyc > 8) done = 1;
      end
    end
    step();
    store_abs = tot_cyc + we_cyc;
    tot_cyc += cyc;
    last_lat = cyc; last_ill = ill_n; last_we_a = we_a; last_we_d = we_d;
    chk("latency", 32'(cyc), 32'(lat_e));
    chk("pc_after", 32'(pc), 32'(m_pc));
    chk("illegal_pulses", 32'(ill_n), 32'(ill_e));
    chk("store_count", 32'(we_n), 32'(st_e));
    if (st_e != 0) begin
      chk("store_addr", 32'(we_a), 32'(sa_e));
      chk("store_data", we_d, sd_e);
      chk("store_cycle", 32'(we_cyc), 32'(lat_e));
    end
    sweep_regs();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0]  rs = 5'($urandom_range(0, 7));
    logic [4:0]  rt = 5'($urandom_range(0, 7));
    logic [4:0]  rd = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    logic [5:0]  fn;
    case ($urandom_range(0, 9))
      0, 1, 2: begin
        case ($urandom_range(0, 5))
          0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
          3: fn = 6'h25; 4: fn = 6'h2A; default: fn = 6'h3F;
        endcase
        return r_ins(fn, rd, rs, rt);
      end
      3, 4: return i_ins(6'h08, rs, rt, imm);
      5: return i_ins(6'h23, rs, rt, imm);
      6: return i_ins(6'h2B, rs, rt, imm);
      7: return i_ins(6'h04, rs, rt, imm);
      8: return {6'h02, 26'($urandom)};
      default: return i_ins(6'h3F - 6'($urandom_range(0, 3)), rs, rt, imm);
    endcase
  endfunction

  initial begin
    logic [4:0] pc_before;
    int sa, sl;
    counterRst = 1'b1;
    counterLd  = 1'b1;
    dbg_raddr  = '0;
    for (int i = 0; i < 32; i++) begin imem[i] = '0; m_reg[i] = '0; end
    for (int i = 0; i < 512; i++) begin dmem[i] = $urandom; m_mem[i] = dmem[i]; end
    m_pc = '0;
    repeat (2) @(posedge clk);
    #5;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    sweep_regs();
    counterRst = 1'b0;

    // addi/addi/add/sw program
    run_instr(i_ins(6'h08, 5'd0, 5'd1, 16'd5), 0, 0);
    run_instr(i_ins(6'h08, 5'd0, 5'd2, 16'd7), 0, 0);
    run_instr(r_ins(6'h20, 5'd3, 5'd1, 5'd2), 0, 0);
    dbg_raddr = 5'd3;
    #1;
    chk("prog_r3", dbg_rdata, 32'd12);
    chk("prog_cycles", 32'(tot_cyc), 32'd12);
    run_instr(i_ins(6'h2B, 5'd0, 5'd3, 16'd4), 0, 0);
    chk("prog_sw_cycle", 32'(store_abs), 32'd16);
    chk("prog_sw_addr", 32'(last_we_a), 32'd4);
    chk("prog_sw_data", last_we_d, 32'd12);
    chk("prog_retires", 32'(retires), 32'd4);

    // load path
    dmem[4] = 32'hDEADBEEF;
    m_mem[4] = 32'hDEADBEEF;
    run_instr(i_ins(6'h23, 5'd0, 5'd5, 16'd4), 0, 0);
    chk("lw_latency", 32'(last_lat), 32'd5);
    dbg_raddr = 5'd5;
    #1;
    chk("lw_r5", dbg_rdata, 32'hDEADBEEF);

    // branches: taken self-loop at 6, not taken at 6, not taken at 31 wraps
    run_instr(i_ins(6'h08, 5'd0, 5'd1, 16'd3), 0, 0);
    run_instr(i_ins(6'h08, 5'd0, 5'd2, 16'd3), 0, 0);
    run_instr({6'h02, 26'd6}, 0, 0);
    run_instr(i_ins(6'h04, 5'd1, 5'd2, 16'hFFFF), 0, 0);
    chk("beq_taken_latency", 32'(last_lat), 32'd3);
    chk("beq_taken_pc", 32'(pc), 32'd6);
    run_instr(i_ins(6'h08, 5'd0, 5'd2, 16'd4), 0, 0);
    run_instr({6'h02, 26'd6}, 0, 0);
    run_instr(i_ins(6'h04, 5'd1, 5'd2, 16'hFFFF), 0, 0);
    chk("beq_not_taken_pc", 32'(pc), 32'd7);
    run_instr({6'h02, 26'd31}, 0, 0);
    run_instr(i_ins(6'h04, 5'd1, 5'd2, 16'hFFFF), 0, 0);
    chk("beq_wrap_pc", 32'(pc), 32'd0);

    // reset while an add sits in EXEC
    run_instr({6'h02, 26'd20}, 0, 0);
    imem[20] = r_ins(6'h20, 5'd3, 5'd1, 5'd2);
    step();
    step();
    counterRst = 1'b1;
    #1;
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_imem_addr", 32'(imem_addr), 32'd0);
    chk("midrst_dmem_we", 32'(dmem_we), 32'd0);
    chk("midrst_retire", 32'(retire), 32'd0);
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_pc = '0;
    sweep_regs();
    step();
    counterRst = 1'b0;
    run_instr(i_ins(6'h08, 5'd0, 5'd6, 16'd1), 0, 0);
    chk("postrst_latency", 32'(last_lat), 32'd4);

    // store frozen for 10 cycles while in MEM, then completes
    run_instr(i_ins(6'h08, 5'd0, 5'd3, 16'h0055), 0, 0);
    run_instr(i_ins(6'h2B, 5'd0, 5'd3, 16'd8), 4, 10);
    chk("stall_sw_addr", 32'(last_we_a), 32'd8);
    chk("stall_sw_data", last_we_d, 32'h55);

    // writes to r0 are dropped
    run_instr(i_ins(6'h08, 5'd0, 5'd0, 16'd9), 0, 0);
    dbg_raddr = 5'd0;
    #1;
    chk("r0_zero", dbg_rdata, 32'd0);

    // signed slt
    run_instr(i_ins(6'h08, 5'd0, 5'd1, 16'hFFFF), 0, 0);
    run_instr(i_ins(6'h08, 5'd0, 5'd2, 16'd1), 0, 0);
    run_instr(r_ins(6'h2A, 5'd4, 5'd1, 5'd2), 0, 0);
    dbg_raddr = 5'd4;
    #1;
    chk("slt_r4", dbg_rdata, 32'd1);

    // illegal opcode
    pc_before = m_pc;
    run_instr(i_ins(6'h3F, 5'd0, 5'd0, 16'd0), 0, 0);
    chk("illegal_pulse", 32'(last_ill), 32'd1);
    chk("illegal_latency", 32'(last_lat), 32'd2);
    chk("illegal_pc", 32'(pc), 32'(pc_before + 5'd1));

    // random instruction stream with occasional freezes
    for (int n = 0; n < 200; n++) begin
      sa = 0;
      sl = 0;
      if ($urandom_range(0, 3) == 0) begin
        sa = $urandom_range(1, 5);
        sl = $urandom_range(1, 3);
      end
      run_instr(rand_ins(), sa, sl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
